// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl
// Synchronous push/pop FIFO between a link-layer source and its consumer.
// Read and write pointers wrap around internally. An occupancy counter
// drives the status flags that are fed back to the source for flow control.
// Sticky error flags record any rejected push or pop.
//
// Ports:
//   clk          rising-edge system clock
//   reset_L      asynchronous active-low reset
//   push         write request; data_in is stored when the push is accepted
//   pop          read request; the word appears on data_out one cycle later
//   data_in      write data
//   data_out     registered read data; holds its value while no pop occurs
//   valid_out    data_out carries a word popped on the previous edge
//   count        occupancy, 0 .. 2**ADDR_WIDTH
//   full, empty  decodes of count
//   almost_full  count >= ALMOST_FULL_TH
//   almost_empty count <= ALMOST_EMPTY_TH
//   overflow     sticky: a push was rejected
//   underflow    sticky: a pop was rejected
module fifo_flow_ctrl #(
  parameter int DATA_WIDTH      = 10,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH     = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH     = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Status flags decode the registered count only.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == {(ADDR_WIDTH+1){1'b0}});
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // Acceptance: a pop at full frees a slot in the same cycle, so push is still taken.
  // A pop at empty is always refused; there is no write-through bypass.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    if (pop && !empty) begin
      pop_ok = 1'b1;
    end else begin
      pop_ok = 1'b0;
    end
    if (push && (!full || pop_ok)) begin
      push_ok = 1'b1;
    end else begin
      push_ok = 1'b0;
    end
  end

  // Storage array: write-only port. No reset, because rows are never read before they are written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data and sticky error flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= {ADDR_WIDTH{1'b0}};
      rd_ptr    <= {ADDR_WIDTH{1'b0}};
      count     <= {(ADDR_WIDTH+1){1'b0}};
      data_out  <= {DATA_WIDTH{1'b0}};
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end

      if (pop_ok) begin
        data_out  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase

      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed testbench for fifo_flow_ctrl with hand-computed expectations.
module tb_fifo_flow_ctrl;

  localparam int DW = 10;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fill_words [8];
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_word;

  fifo_flow_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic pp, input logic [DW-1:0] d);
    push    = ps;
    pop     = pp;
    data_in = d;
  endtask

  task automatic reset_pulse();
    drive(1'b0, 1'b0, 10'h000);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    fill_words = '{10'h091, 10'h04A, 10'h093, 10'h046, 10'h0B5, 10'h164, 10'h1E5, 10'h266};
    reset_L = 1'b0;
    drive(1'b0, 1'b0, 10'h000);
    repeat (2) tick();

    // Reset state.
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    reset_L = 1'b1;

    // Asynchronous reset in the middle of a stream.
    drive(1'b1, 1'b0, 10'h011); tick();
    drive(1'b1, 1'b0, 10'h022); tick();
    drive(1'b1, 1'b0, 10'h033); tick();
    check("mid_count3", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 10'h000);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_unf", 32'(underflow), 32'd0);
    tick();
    reset_L = 1'b1;
    drive(1'b1, 1'b0, 10'h055); tick();
    drive(1'b0, 1'b1, 10'h000); tick();
    check("post_rst_dout", 32'(data_out), 32'h055);
    check("post_rst_valid", 32'(valid_out), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);

    // Fill to depth.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, fill_words[i]); tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end

    // Push while full is rejected.
    drive(1'b1, 1'b0, 10'h3FF); tick();
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);

    // Drain in order, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 10'h000); tick();
      check("drain_dout", 32'(data_out), 32'(fill_words[i]));
      check("drain_valid", 32'(valid_out), 32'd1);
      check("drain_count", 32'(count), 32'(7 - i));
      check("drain_aempty", 32'(almost_empty), (7 - i <= 2) ? 32'd1 : 32'd0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    drive(1'b0, 1'b0, 10'h000); tick();
    check("idle_valid", 32'(valid_out), 32'd0);
    check("idle_hold", 32'(data_out), 32'h266);

    // Pop on empty.
    check("pre_unf", 32'(underflow), 32'd0);
    drive(1'b0, 1'b1, 10'h000); tick();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_valid", 32'(valid_out), 32'd0);
    check("unf_count", 32'(count), 32'd0);
    check("unf_hold", 32'(data_out), 32'h266);

    // Push and pop together on empty.
    reset_pulse();
    check("rst2_unf", 32'(underflow), 32'd0);
    drive(1'b1, 1'b1, 10'h0AA); tick();
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_unf", 32'(underflow), 32'd1);
    check("pp_empty_valid", 32'(valid_out), 32'd0);
    drive(1'b0, 1'b1, 10'h000); tick();
    check("pp_next_dout", 32'(data_out), 32'h0AA);
    check("pp_next_valid", 32'(valid_out), 32'd1);

    // Wrap-around with concurrent push and pop at count 3.
    q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 10'(10'h200 + i)); tick();
      q.push_back(10'(10'h200 + i));
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 10'(10'h100 + i)); tick();
      exp_word = q.pop_front();
      q.push_back(10'(10'h100 + i));
      check("wrap_dout", 32'(data_out), 32'(exp_word));
      check("wrap_count", 32'(count), 32'd3);
    end

    // Fill, then push and pop together while full.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 10'(10'h300 + i)); tick();
      q.push_back(10'(10'h300 + i));
    end
    check("pre_full", 32'(full), 32'd1);
    drive(1'b1, 1'b1, 10'h1C7); tick();
    exp_word = q.pop_front();
    q.push_back(10'h1C7);
    check("ppfull_dout", 32'(data_out), 32'(exp_word));
    check("ppfull_count", 32'(count), 32'd8);
    check("ppfull_ovf", 32'(overflow), 32'd0);
    check("ppfull_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 10'h000); tick();
      exp_word = q.pop_front();
      check("final_dout", 32'(data_out), 32'(exp_word));
    end
    check("final_empty", 32'(empty), 32'd1);

    drive(1'b0, 1'b0, 10'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Parametrised synchronous FIFO with internal wrap-around read/write pointers, occupancy counter, status flags and sticky error flags.
- Generalises the current fixed 10-bit x 8-row memory, where the tester drives addresses directly, into a self-addressing push/pop buffer.
- Sits between a 10-bit link-layer source and its consumer, and feeds flow-control flags back to the source.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8).
- ALMOST_FULL_TH, 6, almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- push  input  1  write request for data_in.
- pop  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data, registered.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset_L low, asynchronous, any cycle including mid-transfer):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, valid_out = 0, overflow = 0, underflow = 0.
  - Memory contents are don't-care and are never read before being written.
- Release is synchronous to clk; the first push is accepted on the first rising edge with reset_L high.
- Storage: 2**ADDR_WIDTH rows of DATA_WIDTH bits; writes are synchronous.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr + 1, wrapping modulo depth.
- Accepted pop: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1, wrapping modulo depth.
- Pop latency: one cycle. The word appears on data_out with valid_out = 1 the cycle after pop is sampled.
- No accepted pop in a cycle: valid_out = 0 and data_out holds its last value.
- Acceptance rules:
  - push alone: accepted if !full; else rejected, overflow <= 1, FIFO state unchanged.
  - pop alone: accepted if !empty; else rejected, underflow <= 1, valid_out = 0.
  - push and pop, 0 < count < depth: both accepted, count unchanged.
  - push and pop while full: both accepted, because the pop frees a slot in the same cycle. Count stays at depth, no overflow.
  - push and pop while empty: push accepted, pop rejected, underflow <= 1, count becomes 1. No write-through bypass.
- Count: +1 for accepted push only, -1 for accepted pop only, unchanged otherwise. Never leaves 0..depth.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count. They update in the cycle after the accepting edge.
- overflow and underflow are cleared only by reset.
- Pointers carry no extra wrap bit; full/empty are derived solely from count.

Test Plan:
- Reset check: assert reset_L = 0 mid-stream after 3 pushes -> count = 0, empty = 1, valid_out = 0, flags 0; a subsequent pop returns the first word pushed after release.
- Fill and drain: push 0x091, 0x04A, 0x093, 0x046, 0x0B5, 0x164, 0x1E5, 0x266 on consecutive edges ->
  - almost_full rises after the 6th push; full = 1 and count = 8 after the 8th.
  - 8 pops return the same words in order, each 1 cycle after its pop with valid_out = 1.
  - empty = 1 after the last pop; almost_empty asserts at count = 2.
- Overflow: fill to 8, push 0x3FF -> overflow = 1, count stays 8, later drain never returns 0x3FF.
- Underflow and simultaneous ops:
  - pop on empty -> underflow = 1, valid_out = 0.
  - push 0x0AA with pop on empty -> count = 1, underflow = 1.
  - next-cycle pop -> 0x0AA.
- Wrap-around and full-boundary concurrency:
  - run 20 pushes and 20 pops interleaved at count 3 -> pointers wrap, data order preserved.
  - at full, push and pop together -> count stays 8, popped word is the oldest, no overflow.
